// File: rtl/simd_sat_alu_pipe.sv
// Two-stage packed-SIMD add/subtract with per-group signed/unsigned saturation,
// sticky per-lane overflow status and a saturating saturation-event counter.
module simd_sat_alu_pipe #(
   parameter  int LANES  = 4,
   parameter  int LANE_W = 4,
   parameter  int CNT_W  = 16,
   localparam int WS     = $clog2(LANES),
   localparam int W      = LANES * LANE_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_a,
   input  logic [W-1:0]     in_b,
   input  logic [WS-1:0]    in_width,
   input  logic             in_sub,
   input  logic             in_sat,
   input  logic             in_uns,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_result,
   output logic [LANES-1:0] out_ovf,
   output logic [LANES-1:0] ovf_sticky,
   input  logic             clr_sticky,
   output logic [CNT_W-1:0] sat_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             s1_valid;
   logic [W-1:0]     s1_a;
   logic [W-1:0]     s1_b;
   logic [WS-1:0]    s1_width;
   logic             s1_sub;
   logic             s1_sat;
   logic             s1_uns;

   logic             s2_valid;
   logic [W-1:0]     s2_result;
   logic [LANES-1:0] s2_ovf;
   logic             s2_evt;
   logic             s2_ready;
   logic             deliver;

   logic [WS-1:0]    g_mask;
   logic [LANES-1:0] grp_lo;
   logic [LANES-1:0] grp_hi;
   logic [W-1:0]     raw_sum;
   logic [W-1:0]     sat_result;
   logic [LANES-1:0] lane_ovf;
   logic             sat_evt;

   logic [LANES-1:0] sticky_nxt;
   logic [CNT_W-1:0] cnt_nxt;

   assign s2_ready = !s2_valid || out_ready;
   assign in_ready = !s1_valid || s2_ready;
   assign deliver  = s2_valid && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_width <= '0;
         s1_sub   <= 1'b0;
         s1_sat   <= 1'b0;
         s1_uns   <= 1'b0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_a     <= in_a;
            s1_b     <= in_b;
            s1_width <= in_width;
            s1_sub   <= in_sub;
            s1_sat   <= in_sat;
            s1_uns   <= in_uns;
         end
      end
   end

   // Lane-index mask for the group; widths beyond log2(LANES) saturate to all ones.
   always_comb begin
      g_mask = '0;
      for (int k = 0; k < WS; k++) begin
         if (k < int'(s1_width)) g_mask[k] = 1'b1;
      end
      grp_lo = '0;
      grp_hi = '0;
      for (int i = 0; i < LANES; i++) begin
         grp_lo[i] = ((WS'(i) & g_mask) == '0);
         grp_hi[i] = ((WS'(i) & g_mask) == g_mask);
      end
   end

   always_comb begin
      logic             carry;
      logic             msb_cin;
      logic [LANE_W-1:0] lb;
      logic [LANE_W:0]   lsum;
      raw_sum  = '0;
      lane_ovf = '0;
      carry    = 1'b0;
      msb_cin  = 1'b0;
      lb       = '0;
      lsum     = '0;
      for (int i = 0; i < LANES; i++) begin
         lb = s1_b[i*LANE_W +: LANE_W] ^ {LANE_W{s1_sub}};
         if (grp_lo[i]) carry = s1_sub;
         lsum = {1'b0, s1_a[i*LANE_W +: LANE_W]} + {1'b0, lb} + {{LANE_W{1'b0}}, carry};
         msb_cin = s1_a[i*LANE_W + LANE_W - 1] ^ lb[LANE_W-1] ^ lsum[LANE_W-1];
         raw_sum[i*LANE_W +: LANE_W] = lsum[LANE_W-1:0];
         if (grp_hi[i]) begin
            lane_ovf[i] = s1_uns ? (lsum[LANE_W] ^ s1_sub) : (msb_cin ^ lsum[LANE_W]);
         end
         carry = lsum[LANE_W];
      end
   end

   // Walk lanes MS to LS so each lane inherits its group's flag and A sign.
   always_comb begin
      logic grp_o;
      logic grp_sign;
      sat_result = raw_sum;
      grp_o      = 1'b0;
      grp_sign   = 1'b0;
      for (int i = LANES - 1; i >= 0; i--) begin
         if (grp_hi[i]) begin
            grp_o    = lane_ovf[i];
            grp_sign = s1_a[i*LANE_W + LANE_W - 1];
         end
         if (s1_sat && grp_o) begin
            if (s1_uns) begin
               sat_result[i*LANE_W +: LANE_W] = {LANE_W{!s1_sub}};
            end else if (grp_hi[i]) begin
               sat_result[i*LANE_W +: LANE_W] = {grp_sign, {(LANE_W-1){!grp_sign}}};
            end else begin
               sat_result[i*LANE_W +: LANE_W] = {LANE_W{!grp_sign}};
            end
         end
      end
      sat_evt = s1_sat && (|lane_ovf);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid  <= 1'b0;
         s2_result <= '0;
         s2_ovf    <= '0;
         s2_evt    <= 1'b0;
      end else if (s2_ready) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_result <= sat_result;
            s2_ovf    <= lane_ovf;
            s2_evt    <= sat_evt;
         end
      end
   end

   // Clear applies before the delivering beat so that beat's event is kept.
   always_comb begin
      sticky_nxt = clr_sticky ? '0 : ovf_sticky;
      cnt_nxt    = clr_sticky ? '0 : sat_count;
      if (deliver) begin
         sticky_nxt = sticky_nxt | s2_ovf;
         if (s2_evt && (cnt_nxt != CNT_MAX)) cnt_nxt = cnt_nxt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_sticky <= '0;
         sat_count  <= '0;
      end else begin
         ovf_sticky <= sticky_nxt;
         sat_count  <= cnt_nxt;
      end
   end

   assign out_valid  = s2_valid;
   assign out_result = s2_result;
   assign out_ovf    = s2_ovf;

endmodule

// File: tb/tb_simd_sat_alu_pipe.sv
// Self-checking bench for simd_sat_alu_pipe: directed scenarios plus randomized
// traffic scored against an integer-arithmetic reference model.
module tb_simd_sat_alu_pipe;

   localparam int LANES  = 4;
   localparam int LANE_W = 4;
   localparam int CNT_W  = 4;
   localparam int WS     = 2;
   localparam int W      = LANES * LANE_W;
   localparam int LOG2   = 2;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     in_a;
   logic [W-1:0]     in_b;
   logic [WS-1:0]    in_width;
   logic             in_sub;
   logic             in_sat;
   logic             in_uns;
   logic             out_valid;
   logic             out_ready;
   logic [W-1:0]     out_result;
   logic [LANES-1:0] out_ovf;
   logic [LANES-1:0] ovf_sticky;
   logic             clr_sticky;
   logic [CNT_W-1:0] sat_count;

   simd_sat_alu_pipe #(.LANES(LANES), .LANE_W(LANE_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_width(in_width),
      .in_sub(in_sub), .in_sat(in_sat), .in_uns(in_uns),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_ovf(out_ovf),
      .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky), .sat_count(sat_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0]     res;
      logic [LANES-1:0] ovf;
      logic             evt;
   } exp_t;

   exp_t             exp_q[$];
   logic [LANES-1:0] exp_sticky;
   int unsigned      exp_cnt;
   int               n_chk;
   int               n_fail;

   bit               t_acc, t_dlv, t_valid, t_rdy;
   logic [W-1:0]     t_res;
   logic [LANES-1:0] t_ovf;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Group-level arithmetic on plain integers.
   function automatic exp_t ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [WS-1:0] wd, input logic sub,
                                   input logic sat, input logic uns);
      exp_t   e;
      int     w, g, n;
      longint ga, gb, sa, sb, r, satv, mask, half;
      bit     o;
      w = int'(wd);
      if (w > LOG2) w = LOG2;
      g    = 1 << w;
      n    = g * LANE_W;
      mask = (longint'(1) << n) - 1;
      half = longint'(1) << (n - 1);
      e    = '0;
      for (int k = 0; k < LANES / g; k++) begin
         ga = longint'(a >> (k * n)) & mask;
         gb = longint'(b >> (k * n)) & mask;
         if (uns) begin
            r    = sub ? ga - gb : ga + gb;
            o    = sub ? (ga < gb) : (r > mask);
            satv = sub ? 0 : mask;
         end else begin
            sa   = (ga >= half) ? ga - (mask + 1) : ga;
            sb   = (gb >= half) ? gb - (mask + 1) : gb;
            r    = sub ? sa - sb : sa + sb;
            o    = (r >= half) || (r < -half);
            satv = (sa < 0) ? half : half - 1;
         end
         r = (sat && o) ? satv : (r & mask);
         e.res = e.res | (W'(r) << (k * n));
         if (o) e.ovf[k*g + g - 1] = 1'b1;
         if (sat && o) e.evt = 1'b1;
      end
      return e;
   endfunction

   // One clock: sample mid-cycle, score deliveries, track status, advance to next negedge.
   task automatic tick();
      exp_t e;
      #1;
      n_chk++;
      if (ovf_sticky !== exp_sticky) begin
         n_fail++;
         $display("FAIL ovf_sticky: got %b expected %b", ovf_sticky, exp_sticky);
      end
      n_chk++;
      if (sat_count !== CNT_W'(exp_cnt)) begin
         n_fail++;
         $display("FAIL sat_count: got %0d expected %0d", sat_count, exp_cnt);
      end
      t_acc   = in_valid && in_ready;
      t_dlv   = out_valid && out_ready;
      t_valid = out_valid;
      t_rdy   = in_ready;
      t_res   = out_result;
      t_ovf   = out_ovf;
      if (t_acc) exp_q.push_back(ref_op(in_a, in_b, in_width, in_sub, in_sat, in_uns));
      if (clr_sticky) begin
         exp_sticky = '0;
         exp_cnt    = 0;
      end
      if (t_dlv) begin
         n_chk++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_beat: got result %h with no beat outstanding", t_res);
         end else begin
            e = exp_q.pop_front();
            if (t_res !== e.res || t_ovf !== e.ovf) begin
               n_fail++;
               $display("FAIL scoreboard: got %h/%b expected %h/%b", t_res, t_ovf, e.res, e.ovf);
            end
            exp_sticky = exp_sticky | e.ovf;
            if (e.evt && exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
         end
      end
      @(negedge clk);
   endtask

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [WS-1:0] wd,
                        input logic sub, input logic sat, input logic uns,
                        output logic [W-1:0] res, output logic [LANES-1:0] ovf, output bit ok);
      in_a = a; in_b = b; in_width = wd; in_sub = sub; in_sat = sat; in_uns = uns;
      in_valid = 1'b1; out_ready = 1'b1;
      ok = 1'b0; res = '0; ovf = '0;
      for (int c = 0; c < 12 && !ok; c++) begin
         tick();
         if (t_acc) in_valid = 1'b0;
         if (t_dlv) begin
            ok  = 1'b1;
            res = t_res;
            ovf = t_ovf;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      n_chk++;
      if (out_valid !== 1'b0 || out_result !== '0 || out_ovf !== '0 ||
          ovf_sticky !== '0 || sat_count !== '0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_state: got v=%b r=%h o=%b s=%b c=%0d rdy=%b expected 0/0/0/0/0/1",
                  out_valid, out_result, out_ovf, ovf_sticky, sat_count, in_ready);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_latency();
      in_a = 16'h7777; in_b = 16'h1111; in_width = 2'd0;
      in_sub = 1'b0; in_sat = 1'b1; in_uns = 1'b0;
      in_valid = 1'b1; out_ready = 1'b1;
      tick();
      n_chk++;
      if (!t_acc) begin n_fail++; $display("FAIL lat_accept: got 0 expected 1"); end
      in_valid = 1'b0;
      tick();
      n_chk++;
      if (t_valid !== 1'b0) begin n_fail++; $display("FAIL lat_cycle1: got %b expected 0", t_valid); end
      tick();
      n_chk++;
      if (t_valid !== 1'b1 || t_res !== 16'h7777 || t_ovf !== 4'b1111) begin
         n_fail++;
         $display("FAIL lat_cycle2: got %b/%h/%b expected 1/7777/1111", t_valid, t_res, t_ovf);
      end
      n_chk++;
      if (sat_count !== 4'd1) begin n_fail++; $display("FAIL lat_count: got %0d expected 1", sat_count); end
   endtask

   task automatic test_group_width();
      logic [W-1:0] r; logic [LANES-1:0] o; bit ok;
      issue(16'h7FFF, 16'h0001, 2'd2, 1'b0, 1'b1, 1'b0, r, o, ok);
      n_chk++;
      if (!ok || r !== 16'h7FFF || o !== 4'b1000 || sat_count !== 4'd2) begin
         n_fail++;
         $display("FAIL w2_sat: got %b/%h/%b/%0d expected 1/7fff/1000/2", ok, r, o, sat_count);
      end
      issue(16'h7FFF, 16'h0001, 2'd2, 1'b0, 1'b0, 1'b0, r, o, ok);
      n_chk++;
      if (!ok || r !== 16'h8000 || o !== 4'b1000 || sat_count !== 4'd2) begin
         n_fail++;
         $display("FAIL w2_wrap: got %b/%h/%b/%0d expected 1/8000/1000/2", ok, r, o, sat_count);
      end
      issue(16'h00FF, 16'h0001, 2'd1, 1'b0, 1'b1, 1'b0, r, o, ok);
      n_chk++;
      if (!ok || r !== 16'h0000 || o !== 4'b0000) begin
         n_fail++;
         $display("FAIL w1_cut: got %b/%h/%b expected 1/0000/0000", ok, r, o);
      end
      issue(16'h7FFF, 16'h0001, 2'd3, 1'b0, 1'b0, 1'b0, r, o, ok);
      n_chk++;
      if (!ok || r !== 16'h8000 || o !== 4'b1000) begin
         n_fail++;
         $display("FAIL w3_clamp: got %b/%h/%b expected 1/8000/1000", ok, r, o);
      end
   endtask

   task automatic test_unsigned();
      logic [W-1:0] r; logic [LANES-1:0] o; bit ok;
      issue(16'h1234, 16'h2222, 2'd0, 1'b1, 1'b1, 1'b1, r, o, ok);
      n_chk++;
      if (!ok || r !== 16'h0012 || o !== 4'b1000) begin
         n_fail++;
         $display("FAIL uns_sub: got %b/%h/%b expected 1/0012/1000", ok, r, o);
      end
      issue(16'hF000, 16'h1000, 2'd0, 1'b0, 1'b0, 1'b1, r, o, ok);
      n_chk++;
      if (!ok || r !== 16'h0000 || o !== 4'b1000) begin
         n_fail++;
         $display("FAIL uns_add_raw: got %b/%h/%b expected 1/0000/1000", ok, r, o);
      end
      issue(16'hF000, 16'h1000, 2'd0, 1'b0, 1'b1, 1'b1, r, o, ok);
      n_chk++;
      if (!ok || r !== 16'hF000 || o !== 4'b1000) begin
         n_fail++;
         $display("FAIL uns_add_sat: got %b/%h/%b expected 1/f000/1000", ok, r, o);
      end
      issue(16'h8000, 16'h0001, 2'd2, 1'b1, 1'b1, 1'b0, r, o, ok);
      n_chk++;
      if (!ok || r !== 16'h8000 || o !== 4'b1000) begin
         n_fail++;
         $display("FAIL sgn_sub_sat: got %b/%h/%b expected 1/8000/1000", ok, r, o);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] ba [3];
      logic [W-1:0] bb [3];
      int idx, acc, run;
      ba[0] = 16'h1111; bb[0] = 16'h1111;
      ba[1] = 16'h0101; bb[1] = 16'h0202;
      ba[2] = 16'h3000; bb[2] = 16'h4000;
      in_width = 2'd0; in_sub = 1'b0; in_sat = 1'b0; in_uns = 1'b0;
      out_ready = 1'b0;
      idx = 0; acc = 0;
      in_a = ba[0]; in_b = bb[0]; in_valid = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (t_acc) begin
            acc++; idx++;
            if (idx < 3) begin in_a = ba[idx]; in_b = bb[idx]; end
         end
      end
      n_chk++;
      if (acc != 2 || t_rdy !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_backpressure: got accepts=%0d ready=%b expected 2/0", acc, t_rdy);
      end
      for (int c = 0; c < 3; c++) begin
         tick();
         n_chk++;
         if (t_valid !== 1'b1 || t_res !== 16'h2222 || t_ovf !== 4'b0000) begin
            n_fail++;
            $display("FAIL b2b_hold: got %b/%h/%b expected 1/2222/0000", t_valid, t_res, t_ovf);
         end
      end
      out_ready = 1'b1;
      run = 0;
      for (int c = 0; c < 3; c++) begin
         tick();
         if (t_acc) in_valid = 1'b0;
         if (t_dlv) run++;
      end
      in_valid = 1'b0;
      n_chk++;
      if (run != 3) begin n_fail++; $display("FAIL b2b_drain: got %0d deliveries expected 3", run); end
      tick();
      n_chk++;
      if (t_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: got %b expected 0", t_valid); end
   endtask

   task automatic test_clr_sticky();
      logic [W-1:0] r; logic [LANES-1:0] o; bit ok;
      issue(16'h0007, 16'h0001, 2'd0, 1'b0, 1'b1, 1'b0, r, o, ok);
      n_chk++;
      if (!ok || r !== 16'h0007 || o !== 4'b0001) begin
         n_fail++;
         $display("FAIL clr_pre: got %b/%h/%b expected 1/0007/0001", ok, r, o);
      end
      out_ready = 1'b0;
      in_a = 16'h7FFF; in_b = 16'h0001; in_width = 2'd2; in_sub = 1'b0; in_sat = 1'b1; in_uns = 1'b0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      clr_sticky = 1'b1; out_ready = 1'b1;
      tick();
      clr_sticky = 1'b0;
      n_chk++;
      if (!t_dlv || sat_count !== 4'd1 || ovf_sticky !== 4'b1000) begin
         n_fail++;
         $display("FAIL clr_with_delivery: got dlv=%b cnt=%0d sticky=%b expected 1/1/1000",
                  t_dlv, sat_count, ovf_sticky);
      end
   endtask

   task automatic test_count_saturate();
      logic [W-1:0] r; logic [LANES-1:0] o; bit ok;
      for (int i = 0; i < 16; i++) issue(16'h7777, 16'h1111, 2'd0, 1'b0, 1'b1, 1'b0, r, o, ok);
      n_chk++;
      if (sat_count !== 4'hF) begin n_fail++; $display("FAIL cnt_saturate: got %0d expected 15", sat_count); end
      clr_sticky = 1'b1;
      tick();
      clr_sticky = 1'b0;
      n_chk++;
      if (sat_count !== '0 || ovf_sticky !== '0) begin
         n_fail++;
         $display("FAIL clr_idle: got cnt=%0d sticky=%b expected 0/0", sat_count, ovf_sticky);
      end
   endtask

   task automatic test_random();
      in_valid = 1'b0;
      for (int c = 0; c < 800; c++) begin
         if (!in_valid || t_acc) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_a     = W'($urandom);
            in_b     = W'($urandom);
            in_width = WS'($urandom_range(0, 3));
            in_sub   = 1'($urandom);
            in_sat   = 1'($urandom);
            in_uns   = 1'($urandom);
         end
         out_ready  = ($urandom_range(0, 9) < 7);
         clr_sticky = ($urandom_range(0, 24) == 0);
         tick();
      end
      in_valid = 1'b0; clr_sticky = 1'b0; out_ready = 1'b1;
      for (int c = 0; c < 10 && exp_q.size() != 0; c++) tick();
      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL rand_drain: got %0d beats outstanding expected 0", exp_q.size());
      end
   endtask

   task automatic test_reset_midflight();
      bit seen;
      out_ready = 1'b0;
      in_a = 16'h7FFF; in_b = 16'h0001; in_width = 2'd2; in_sub = 1'b0; in_sat = 1'b1; in_uns = 1'b0;
      in_valid = 1'b1;
      tick();
      tick();
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      n_chk++;
      if (out_valid !== 1'b0 || out_result !== '0 || out_ovf !== '0 ||
          ovf_sticky !== '0 || sat_count !== '0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL midflight_reset: got v=%b r=%h o=%b s=%b c=%0d rdy=%b expected 0/0/0/0/0/1",
                  out_valid, out_result, out_ovf, ovf_sticky, sat_count, in_ready);
      end
      exp_q.delete();
      exp_sticky = '0;
      exp_cnt    = 0;
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (t_valid) seen = 1'b1;
      end
      n_chk++;
      if (seen) begin n_fail++; $display("FAIL midflight_ghost: got out_valid=1 expected 0 after reset"); end
   endtask

   initial begin
      n_chk = 0; n_fail = 0;
      exp_sticky = '0; exp_cnt = 0;
      t_acc = 0; t_dlv = 0; t_valid = 0; t_rdy = 0; t_res = '0; t_ovf = '0;
      rst = 1'b1;
      in_valid = 1'b0; in_a = '0; in_b = '0; in_width = '0;
      in_sub = 1'b0; in_sat = 1'b0; in_uns = 1'b0;
      out_ready = 1'b0; clr_sticky = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      test_latency();
      test_group_width();
      test_unsigned();
      test_back_to_back();
      test_clr_sticky();
      test_count_saturate();
      test_random();
      test_reset_midflight();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/simd_sat_alu_pipe.md
Name: simd_sat_alu_pipe

Overview:
Parametrised, pipelined packed-SIMD add/subtract unit with per-group signed or unsigned saturation. It generalises the fixed 4-lane carry/saturation steering to LANES lanes of LANE_W bits. Lanes are grouped into power-of-two partitions selected per operation. It sits between the operand fetch and the writeback stage of the M16 datapath, using a valid/ready handshake on both sides. It also provides sticky per-lane overflow status and a saturation event counter.

Parameters:
LANES, 4, number of base lanes; power of two, at least 2.
LANE_W, 4, bits per base lane; the data word is LANES*LANE_W bits.
CNT_W, 16, width of the saturation event counter.

Ports:
clk  in  1  single clock; all state updates on the rising edge.
rst  in  1  reset; asynchronous, active-high.
in_valid  in  1  operand beat valid.
in_ready  out  1  unit can accept a beat this cycle.
in_a  in  LANES*LANE_W  operand A; lane 0 is the LS bits.
in_b  in  LANES*LANE_W  operand B.
in_width  in  WS=$clog2(LANES)  group size is 2^in_width lanes; values above log2(LANES) clamp to full word.
in_sub  in  1  1 = A-B, 0 = A+B.
in_sat  in  1  saturation enable.
in_uns  in  1  1 = unsigned saturation, 0 = signed.
out_valid  out  1  result beat valid.
out_ready  in  1  consumer accepts the result.
out_result  out  LANES*LANE_W  packed result.
out_ovf  out  LANES  per-group overflow, reported on each group's MS lane bit; other bits are 0.
ovf_sticky  out  LANES  OR-accumulated out_ovf over delivered beats.
clr_sticky  in  1  synchronous clear of ovf_sticky and sat_count.
sat_count  out  CNT_W  count of delivered beats where saturation replaced at least one group; holds at all-ones.

Behaviour:
- Pipeline
  - Two register stages. S1 captures operands and controls. S2 holds the computed result and flags.
  - Each stage loads when it is empty or its contents move downstream in the same cycle.
  - in_ready = !s1_valid | (!s2_valid | out_ready). It is combinational and has no dependency on in_valid.
  - A beat is accepted when in_valid & in_ready, and delivered when out_valid & out_ready.
  - Latency: accept in cycle N gives out_valid in cycle N+2 when there is no stall. Throughput is 1 beat/cycle.
  - While out_ready=0, out_result, out_ovf and out_valid hold stable. At most 2 beats are in flight. Order is preserved and no beat is dropped or duplicated.
- Arithmetic, computed combinationally between S1 and S2
  - Subtract is A + ~B + 1, with the +1 injected at each group's lane 0.
  - Carry propagates between lanes only within a group. It is cut at every group boundary.
  - Signed overflow per group: the carry into the MSB differs from the carry out of the MSB.
  - Unsigned overflow per group: add uses carry-out=1; sub uses borrow, i.e. carry-out=0.
  - out_ovf is set on overflow regardless of in_sat.
- Saturation (in_sat=1, overflowed group only)
  - Signed: A's group sign 0 gives 0111..1; sign 1 gives 1000..0.
  - Unsigned: add gives all ones; sub gives all zeros.
  - Non-overflowed groups pass the raw sum.
  - With in_sat=0 the raw wrapped sum is output.
- Status, updated only on delivery
  - ovf_sticky |= out_ovf.
  - sat_count increments by 1 if in_sat and any out_ovf bit is set. It saturates at 2^CNT_W-1.
  - clr_sticky coinciding with a delivery: clear first, then apply that beat's contribution. The new event survives.
- Reset (asynchronous)
  - s1_valid, s2_valid, out_valid, out_result, out_ovf, ovf_sticky and sat_count all go to 0. in_ready is 1 after reset.
  - Reset mid-operation discards all in-flight beats. No output is produced for them after release.

Test Plan:
1. LANES=4, LANE_W=4, width=0, add, sat signed, A=0x7777, B=0x1111 -> out_result=0x7777, out_ovf=1111, sat_count=1, latency 2 cycles.
2. width=2, add, A=0x7FFF, B=0x0001: with sat=1 -> 0x7FFF, out_ovf=1000; with sat=0 -> 0x8000, out_ovf=1000; sat_count increments only on the sat=1 beat.
3. width=1, add, sat=1, A=0x00FF, B=0x0001 -> 0x0000, out_ovf=0000; no carry crosses into bits [15:8].
4. width=0, sub, uns=1, sat=1, A=0x1234, B=0x2222 -> 0x0012, out_ovf=1000; then width=0, add, uns=1, A=0xF000, B=0x1000 -> 0x0000 raw, or 0xF000 with sat, out_ovf=1000.
5. Issue 3 back-to-back beats with out_ready=0 -> in_ready falls after 2 accepts. out_result is stable. Releasing out_ready delivers all 3 in order on consecutive cycles.
6. Assert clr_sticky in the same cycle a saturating beat is delivered -> sat_count=1 and ovf_sticky holds only that beat's bits. Then pulse rst with 2 beats in flight -> out_valid=0, outputs and status zero, nothing is emitted after release.
